ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline; consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Contains the ALU-control decode, the forwarding unit and operand muxes, the ALU, and an iterative RV32M MUL unit.
- While MUL runs, the stage stalls PC, IF/ID and ID/EX, and injects bubbles into EX/MEM.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle; legal values 1, 2, 4.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
idex_rs1_data_i  in  32  rs1 read data from ID/EX
idex_rs2_data_i  in  32  rs2 read data from ID/EX
idex_imm_i  in  32  sign-extended immediate
idex_funct_i  in  10  {funct7, funct3}
idex_rs1_addr_i  in  5  rs1 index
idex_rs2_addr_i  in  5  rs2 index
idex_aluop_i  in  2  ALUOp
idex_alusrc_i  in  1  1 = operand B is immediate
exmem_regwrite_i  in  1  EX/MEM RegWrite
exmem_rd_i  in  5  EX/MEM rd
exmem_result_i  in  32  EX/MEM ALU result
memwb_regwrite_i  in  1  MEM/WB RegWrite
memwb_rd_i  in  5  MEM/WB rd
memwb_wdata_i  in  32  MEM/WB write-back data
alu_result_o  out  32  to EX/MEM
store_data_o  out  32  forwarded rs2 value, to EX/MEM
stall_o  out  1  hold PC, IF/ID and ID/EX
bubble_o  out  1  EX/MEM loads zero control signals this edge

Behaviour:
- Reset: synchronous and active-high; all registers clear at the rising edge while rst_i=1.
  - FSM goes to IDLE; counter, multiplicand, multiplier and product registers are cleared to 0.
  - stall_o and bubble_o are forced to 0 while rst_i=1.
  - Reset mid-MUL abandons the operation; no result is produced.
- ALUOp decode:
  - 00 -> ADD (lw/sw).
  - 01 -> SUB (beq).
  - 10 -> R-type by funct: 0000000_111 AND, 0000000_100 XOR, 0000000_001 SLL, 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL.
  - 11 -> I-type by funct3: 000 ADDI, 101 SRAI with shamt = imm[4:0].
  - Any undefined code yields ADD.
- Forwarding, per operand (A on rs1, B on rs2):
  - EX/MEM wins if its RegWrite=1, its rd!=0 and its rd equals the operand's rs address.
  - Otherwise MEM/WB wins under the same three conditions.
  - Otherwise the ID/EX data is used.
  - x0 is never forwarded.
- Operand B: the immediate when idex_alusrc_i=1, else forwarded rs2.
- store_data_o always carries forwarded rs2.
- Arithmetic: 32-bit modulo wrap, no overflow flag. SLL uses B[4:0]. SRAI is arithmetic. MUL returns the low 32 bits of the product.
- Non-MUL ops: combinational, zero added latency; stall_o=0 and bubble_o=0.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE, with MUL present on the inputs (cycle T0):
    - stall_o=1 and bubble_o=1.
    - At the edge: capture forwarded A and B, clear the product, counter=0, go to BUSY.
    - Operands must be captured at T0, because forwarding sources drain as bubbles afterwards.
  - BUSY:
    - stall_o=1 and bubble_o=1.
    - Each edge performs shift-add over MUL_BITS_PER_CYCLE multiplier bits and counter += MUL_BITS_PER_CYCLE.
    - When the counter reaches 32, go to DONE.
  - DONE:
    - stall_o=0 and bubble_o=0; alu_result_o = product.
    - At the edge, EX/MEM captures the result, ID/EX advances, and the FSM goes to IDLE.
  - Total EX occupancy = 32/MUL_BITS_PER_CYCLE + 2 cycles (34 at the default).
- Back-to-back MUL: the second MUL is seen in IDLE on the cycle after DONE and restarts the sequence.
- A non-MUL on the inputs in BUSY or DONE cannot occur, because ID/EX is held. The FSM ignores the inputs in those states.
- alu_result_o is don't-care while bubble_o=1.

Decomposition:
- Package rv_ex_pkg holds:
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I).
  - 10-bit funct constants.
  - ALU control enum (AND, XOR, SLL, ADD, SUB, MUL, SRA).
  - Forward-select encodings (FWD_IDEX=00, FWD_MEMWB=01, FWD_EXMEM=10).
  - MUL FSM state enum.
- One sub-module, mul_iter: start/done handshake, holds the multiplicand, multiplier, product and counter, parameterised by MUL_BITS_PER_CYCLE.

Test Plan:
- ADD with rs1=5 (data 7) and rs2=6 (data 9), no hazards -> alu_result_o=16; stall_o=0.
- SUB where EX/MEM has rd=5, RegWrite=1, result 100 and MEM/WB has rd=5, result 50; rs1=5 (ID/EX data 1), rs2 data 30 -> A=100 (EX/MEM priority), result 70.
- Forward to x0: EX/MEM rd=0, RegWrite=1, result 0xDEAD; rs1=0 with ID/EX data 0 -> no forward, ADDI imm=4 gives 4.
- SRAI with A=0x80000010 and imm shamt=4 -> 0xF8000001. SLL with A=1 and B=0x23 -> 8.
- MUL 0xFFFFFFFF x 3, default parameter:
  - stall_o high for exactly 33 cycles, then DONE with result 0xFFFFFFFD.
  - bubble_o is high on the same cycles as stall_o.
  - Operands are forwarded from EX/MEM at T0; EX/MEM changes afterwards and the result is unchanged.
- Assert rst_i at BUSY count 10 -> next cycle is IDLE with stall_o=0. A following MUL 6 x 7 gives 42; repeat with MUL_BITS_PER_CYCLE=4 and expect 8 BUSY cycles.

Source files
------------

// File: rtl/rv_ex_pkg.sv
// Shared encodings for the RV32 execute stage: ALUOp, funct codes, ALU control,
// forwarding selects and the MUL sequencer states, plus the two decode helpers.
package rv_ex_pkg;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   // {funct7, funct3}
   localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
   localparam logic [9:0] FUNCT_XOR = 10'b0000000_100;
   localparam logic [9:0] FUNCT_SLL = 10'b0000000_001;
   localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
   localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
   localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

   localparam logic [2:0] FUNCT3_ADDI = 3'b000;
   localparam logic [2:0] FUNCT3_SRAI = 3'b101;

   typedef enum logic [2:0] {
      ALU_AND, ALU_XOR, ALU_SLL, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SRA
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      FWD_IDEX  = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      MUL_IDLE, MUL_BUSY, MUL_DONE
   } mul_state_t;

   function automatic alu_ctrl_t alu_decode(input logic [1:0] aluop, input logic [9:0] funct);
      alu_ctrl_t ctrl;
      ctrl = ALU_ADD;
      case (aluop)
         ALUOP_ADD: ctrl = ALU_ADD;
         ALUOP_SUB: ctrl = ALU_SUB;
         ALUOP_R: begin
            case (funct)
               FUNCT_AND: ctrl = ALU_AND;
               FUNCT_XOR: ctrl = ALU_XOR;
               FUNCT_SLL: ctrl = ALU_SLL;
               FUNCT_ADD: ctrl = ALU_ADD;
               FUNCT_SUB: ctrl = ALU_SUB;
               FUNCT_MUL: ctrl = ALU_MUL;
               default:   ctrl = ALU_ADD;
            endcase
         end
         ALUOP_I: begin
            case (funct[2:0])
               FUNCT3_ADDI: ctrl = ALU_ADD;
               FUNCT3_SRAI: ctrl = ALU_SRA;
               default:     ctrl = ALU_ADD;
            endcase
         end
         default: ctrl = ALU_ADD;
      endcase
      return ctrl;
   endfunction

   // The younger producer (EX/MEM) wins; x0 is hard-wired zero and never forwarded.
   function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                           input logic       exmem_regwrite,
                                           input logic [4:0] exmem_rd,
                                           input logic       memwb_regwrite,
                                           input logic [4:0] memwb_rd);
      fwd_sel_t sel;
      sel = FWD_IDEX;
      if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs)
         sel = FWD_EXMEM;
      else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs)
         sel = FWD_MEMWB;
      return sel;
   endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: captures operands on start in IDLE, retires
// MUL_BITS_PER_CYCLE multiplier bits per BUSY cycle, presents the product in DONE.
module mul_iter
   import rv_ex_pkg::*;
#(
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        idle,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   localparam logic [5:0] STEP = 6'(MUL_BITS_PER_CYCLE);
   localparam logic [5:0] LAST = 6'(32 - MUL_BITS_PER_CYCLE);

   mul_state_t  state;
   logic [5:0]  count;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] partial;

   always_comb begin
      // NOTE: give every always_comb output a default first, so no path can infer a latch.
      partial = '0;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++)
         if (mplier[i]) partial = partial + (mcand << i);
   end

   // NOTE: sequential state uses non-blocking <= so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MUL_IDLE;
         count   <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else begin
         case (state)
            MUL_IDLE: begin
               if (start) begin
                  mcand   <= op_a;
                  mplier  <= op_b;
                  product <= '0;
                  count   <= '0;
                  state   <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               product <= product + partial;
               mcand   <= mcand << MUL_BITS_PER_CYCLE;
               mplier  <= mplier >> MUL_BITS_PER_CYCLE;
               count   <= count + STEP;
               if (count == LAST) state <= MUL_DONE;
            end
            MUL_DONE: state <= MUL_IDLE;
            default:  state <= MUL_IDLE;
         endcase
      end
   end

   assign idle = (state == MUL_IDLE);
   assign busy = (state == MUL_BUSY);
   assign done = (state == MUL_DONE);

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU-control decode, forwarding muxes, ALU and the
// iterative MUL unit that stalls the front of the pipe while it runs.
module ex_stage
   import rv_ex_pkg::*;
#(
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] idex_rs1_data_i,
   input  logic [31:0] idex_rs2_data_i,
   input  logic [31:0] idex_imm_i,
   input  logic [9:0]  idex_funct_i,
   input  logic [4:0]  idex_rs1_addr_i,
   input  logic [4:0]  idex_rs2_addr_i,
   input  logic [1:0]  idex_aluop_i,
   input  logic        idex_alusrc_i,
   input  logic        exmem_regwrite_i,
   input  logic [4:0]  exmem_rd_i,
   input  logic [31:0] exmem_result_i,
   input  logic        memwb_regwrite_i,
   input  logic [4:0]  memwb_rd_i,
   input  logic [31:0] memwb_wdata_i,
   output logic [31:0] alu_result_o,
   output logic [31:0] store_data_o,
   output logic        stall_o,
   output logic        bubble_o
);

   alu_ctrl_t   ctrl;
   fwd_sel_t    sel_a;
   fwd_sel_t    sel_b;
   logic [31:0] fwd_a;
   logic [31:0] fwd_b;
   logic [31:0] op_b;
   logic [31:0] product;
   logic        mul_idle;
   logic        mul_busy;
   logic        mul_done;

   assign ctrl  = alu_decode(idex_aluop_i, idex_funct_i);
   assign sel_a = fwd_select(idex_rs1_addr_i, exmem_regwrite_i, exmem_rd_i,
                             memwb_regwrite_i, memwb_rd_i);
   assign sel_b = fwd_select(idex_rs2_addr_i, exmem_regwrite_i, exmem_rd_i,
                             memwb_regwrite_i, memwb_rd_i);

   assign fwd_a = (sel_a == FWD_EXMEM) ? exmem_result_i :
                  (sel_a == FWD_MEMWB) ? memwb_wdata_i  : idex_rs1_data_i;
   assign fwd_b = (sel_b == FWD_EXMEM) ? exmem_result_i :
                  (sel_b == FWD_MEMWB) ? memwb_wdata_i  : idex_rs2_data_i;

   assign op_b         = idex_alusrc_i ? idex_imm_i : fwd_b;
   assign store_data_o = fwd_b;

   // Operands are captured from the forwarded values at T0; the producers drain afterwards.
   mul_iter #(
      .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
   ) u_mul (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   (ctrl == ALU_MUL),
      .op_a    (fwd_a),
      .op_b    (fwd_b),
      .idle    (mul_idle),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   assign stall_o  = !rst_i && (mul_busy || (mul_idle && ctrl == ALU_MUL));
   assign bubble_o = stall_o;

   always_comb begin
      alu_result_o = fwd_a + op_b;
      case (ctrl)
         ALU_AND: alu_result_o = fwd_a & op_b;
         ALU_XOR: alu_result_o = fwd_a ^ op_b;
         ALU_SLL: alu_result_o = fwd_a << op_b[4:0];
         ALU_ADD: alu_result_o = fwd_a + op_b;
         ALU_SUB: alu_result_o = fwd_a - op_b;
         ALU_MUL: alu_result_o = mul_done ? product : 32'd0;
         ALU_SRA: alu_result_o = $signed(fwd_a) >>> idex_imm_i[4:0];
         default: alu_result_o = fwd_a + op_b;
      endcase
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table-driven combinational vectors plus MUL sequences,
// run on a 1-bit/cycle and a 4-bit/cycle instance sharing the same stimulus.
module tb_ex_stage;

   typedef struct {
      string       name;
      logic [1:0]  aluop;
      logic [9:0]  funct;
      logic        alusrc;
      logic [4:0]  rs1;
      logic [31:0] rs1_data;
      logic [4:0]  rs2;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        exmem_rw;
      logic [4:0]  exmem_rd;
      logic [31:0] exmem_res;
      logic        memwb_rw;
      logic [4:0]  memwb_rd;
      logic [31:0] memwb_wdata;
      logic [31:0] exp_result;
      logic [31:0] exp_store;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] result;
      logic [31:0] store;
      int          stalls;
   } sb_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] idex_rs1_data_i, idex_rs2_data_i, idex_imm_i;
   logic [9:0]  idex_funct_i;
   logic [4:0]  idex_rs1_addr_i, idex_rs2_addr_i;
   logic [1:0]  idex_aluop_i;
   logic        idex_alusrc_i;
   logic        exmem_regwrite_i;
   logic [4:0]  exmem_rd_i;
   logic [31:0] exmem_result_i;
   logic        memwb_regwrite_i;
   logic [4:0]  memwb_rd_i;
   logic [31:0] memwb_wdata_i;

   logic [31:0] alu_result1, store_data1, alu_result4, store_data4;
   logic        stall1, bubble1, stall4, bubble4;

   int n_cmp = 0;
   int n_bad = 0;
   sb_t sb1[$];
   sb_t sb4[$];
   vec_t vecs[$];

   always #5 clk_i = ~clk_i;

   ex_stage #(.MUL_BITS_PER_CYCLE(1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i),
      .idex_rs1_data_i(idex_rs1_data_i), .idex_rs2_data_i(idex_rs2_data_i),
      .idex_imm_i(idex_imm_i), .idex_funct_i(idex_funct_i),
      .idex_rs1_addr_i(idex_rs1_addr_i), .idex_rs2_addr_i(idex_rs2_addr_i),
      .idex_aluop_i(idex_aluop_i), .idex_alusrc_i(idex_alusrc_i),
      .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
      .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_wdata_i(memwb_wdata_i),
      .alu_result_o(alu_result1), .store_data_o(store_data1), .stall_o(stall1), .bubble_o(bubble1)
   );

   ex_stage #(.MUL_BITS_PER_CYCLE(4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i),
      .idex_rs1_data_i(idex_rs1_data_i), .idex_rs2_data_i(idex_rs2_data_i),
      .idex_imm_i(idex_imm_i), .idex_funct_i(idex_funct_i),
      .idex_rs1_addr_i(idex_rs1_addr_i), .idex_rs2_addr_i(idex_rs2_addr_i),
      .idex_aluop_i(idex_aluop_i), .idex_alusrc_i(idex_alusrc_i),
      .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
      .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_wdata_i(memwb_wdata_i),
      .alu_result_o(alu_result4), .store_data_o(store_data4), .stall_o(stall4), .bubble_o(bubble4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      idex_aluop_i     = v.aluop;
      idex_funct_i     = v.funct;
      idex_alusrc_i    = v.alusrc;
      idex_rs1_addr_i  = v.rs1;
      idex_rs1_data_i  = v.rs1_data;
      idex_rs2_addr_i  = v.rs2;
      idex_rs2_data_i  = v.rs2_data;
      idex_imm_i       = v.imm;
      exmem_regwrite_i = v.exmem_rw;
      exmem_rd_i       = v.exmem_rd;
      exmem_result_i   = v.exmem_res;
      memwb_regwrite_i = v.memwb_rw;
      memwb_rd_i       = v.memwb_rd;
      memwb_wdata_i    = v.memwb_wdata;
   endtask

   task automatic apply_nop();
      vec_t v;
      v = '{"nop", 2'b00, 10'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0,
            1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0};
      apply(v);
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      apply_nop();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   task automatic check_comb();
      sb_t e;
      if (sb1.size() == 0 || sb4.size() == 0) begin
         check("scoreboard_empty", 32'(sb1.size() + sb4.size()), 32'd2);
         return;
      end
      e = sb1.pop_front();
      check({e.name, "_res1"},    alu_result1, e.result);
      check({e.name, "_store1"},  store_data1, e.store);
      check({e.name, "_stall1"},  32'(stall1), 32'd0);
      check({e.name, "_bubble1"}, 32'(bubble1), 32'd0);
      e = sb4.pop_front();
      check({e.name, "_res4"},    alu_result4, e.result);
      check({e.name, "_store4"},  store_data4, e.store);
      check({e.name, "_stall4"},  32'(stall4), 32'd0);
   endtask

   // Counts stall cycles of both instances until each shows its result; after the
   // T0 sample the EX/MEM forwarding source is changed to prove operands were latched.
   task automatic watch_mul(input int limit);
      int  n1 = 0;
      int  n4 = 0;
      bit  f1 = 1'b0;
      bit  f4 = 1'b0;
      sb_t e;
      for (int c = 0; c < limit && !(f1 && f4); c++) begin
         @(negedge clk_i);
         if (!f1) begin
            check("bubble_eq_stall1", 32'(bubble1), 32'(stall1));
            if (stall1) n1++;
            else if (sb1.size() != 0) begin
               f1 = 1'b1;
               e  = sb1.pop_front();
               check({e.name, "_res1"},    alu_result1, e.result);
               check({e.name, "_store1"},  store_data1, e.store);
               check({e.name, "_stalls1"}, 32'(n1), 32'(e.stalls));
            end
         end
         if (!f4) begin
            check("bubble_eq_stall4", 32'(bubble4), 32'(stall4));
            if (stall4) n4++;
            else if (sb4.size() != 0) begin
               f4 = 1'b1;
               e  = sb4.pop_front();
               check({e.name, "_res4"},    alu_result4, e.result);
               check({e.name, "_stalls4"}, 32'(n4), 32'(e.stalls));
            end
         end
         if (c == 0) begin
            @(posedge clk_i); #1;
            exmem_result_i = 32'h1234_5678;
            memwb_wdata_i  = 32'h0BAD_F00D;
         end
      end
      check("mul_completed1", 32'(f1), 32'd1);
      check("mul_completed4", 32'(f4), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      vec_t v;

      vecs = '{
         '{"add",        2'b10, 10'b0000000_000, 1'b0, 5,  32'd7,         6,  32'd9,         32'd0,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'd16,        32'd9},
         '{"sub_fwd",    2'b10, 10'b0100000_000, 1'b0, 5,  32'd1,         6,  32'd30,        32'd0,
           1'b1, 5, 32'd100, 1'b1, 5, 32'd50,        32'd70,        32'd30},
         '{"addi_x0",    2'b11, 10'b0000000_000, 1'b1, 0,  32'd0,         0,  32'd0,         32'd4,
           1'b1, 0, 32'hDEAD, 1'b0, 0, 32'd0,        32'd4,         32'd0},
         '{"srai",       2'b11, 10'b0100000_101, 1'b1, 2,  32'h8000_0010, 0,  32'd0,         32'h404,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'hF800_0001, 32'd0},
         '{"sll",        2'b10, 10'b0000000_001, 1'b0, 1,  32'd1,         2,  32'h23,        32'd0,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'd8,         32'h23},
         '{"and_wb",     2'b10, 10'b0000000_111, 1'b0, 4,  32'hF0F0_FF00, 7,  32'd0,         32'd0,
           1'b0, 0, 32'd0,   1'b1, 7, 32'h0FF0_0FF0, 32'h00F0_0F00, 32'h0FF0_0FF0},
         '{"xor",        2'b10, 10'b0000000_100, 1'b0, 8,  32'hAAAA_5555, 9,  32'hFFFF_0000, 32'd0,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'h5555_5555, 32'hFFFF_0000},
         '{"lw_add",     2'b00, 10'b0000001_000, 1'b1, 10, 32'h1000,      11, 32'h77,        32'hFFFF_FFFC,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'hFFC,       32'h77},
         '{"beq_sub",    2'b01, 10'b0000000_111, 1'b0, 12, 32'd5,         13, 32'd5,         32'd0,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'd0,         32'd5},
         '{"r_undef",    2'b10, 10'b0000000_010, 1'b0, 14, 32'd3,         15, 32'd4,         32'd0,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'd7,         32'd4},
         '{"add_wrap",   2'b10, 10'b0000000_000, 1'b0, 16, 32'hFFFF_FFFF, 17, 32'd2,         32'd0,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'd1,         32'd2},
         '{"wb_when_exmem_nowrite", 2'b10, 10'b0000000_000, 1'b0, 3, 32'd5, 18, 32'd0,       32'd0,
           1'b0, 3, 32'd111, 1'b1, 3, 32'd222,       32'd222,       32'd0},
         '{"i_undef",    2'b11, 10'b0000000_010, 1'b1, 19, 32'd10,        20, 32'd0,         32'd5,
           1'b0, 0, 32'd0,   1'b0, 0, 32'd0,         32'd15,        32'd0},
         '{"fwd_b_exmem", 2'b10, 10'b0000000_000, 1'b0, 21, 32'd1,        22, 32'd2,         32'd0,
           1'b1, 22, 32'd40, 1'b1, 22, 32'd50,       32'd41,        32'd40}
      };

      rst_i = 1'b1;
      apply_nop();
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("reset_stall1",  32'(stall1),  32'd0);
      check("reset_bubble1", 32'(bubble1), 32'd0);
      check("reset_stall4",  32'(stall4),  32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_reset_stall1", 32'(stall1), 32'd0);
      check("post_reset_res1",   alu_result1, 32'd0);

      foreach (vecs[i]) begin
         @(posedge clk_i); #1;
         apply(vecs[i]);
         sb1.push_back('{vecs[i].name, vecs[i].exp_result, vecs[i].exp_store, 0});
         sb4.push_back('{vecs[i].name, vecs[i].exp_result, vecs[i].exp_store, 0});
         @(negedge clk_i);
         check_comb();
      end

      // MUL 0xFFFFFFFF x 3 with rs1 forwarded from EX/MEM at T0.
      do_reset();
      v = '{"mul_fwd", 2'b10, 10'b0000001_000, 1'b0, 5, 32'd0, 6, 32'd3, 32'd0,
            1'b1, 5, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'd0, 32'd0};
      apply(v);
      sb1.push_back('{"mul_fwd", 32'hFFFF_FFFD, 32'd3, 33});
      sb4.push_back('{"mul_fwd", 32'hFFFF_FFFD, 32'd3, 9});
      watch_mul(80);

      // Reset after ten BUSY edges abandons the multiply.
      do_reset();
      v = '{"mul_abort", 2'b10, 10'b0000001_000, 1'b0, 1, 32'd5, 2, 32'd5, 32'd0,
            1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 32'd0};
      apply(v);
      @(negedge clk_i);
      check("abort_t0_stall1", 32'(stall1), 32'd1);
      repeat (11) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("abort_rst_stall1",  32'(stall1),  32'd0);
      check("abort_rst_bubble1", 32'(bubble1), 32'd0);
      check("abort_rst_stall4",  32'(stall4),  32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      apply_nop();
      @(negedge clk_i);
      check("abort_idle_stall1", 32'(stall1), 32'd0);
      check("abort_idle_res1",   alu_result1, 32'd0);
      @(negedge clk_i);
      check("abort_idle2_stall1", 32'(stall1), 32'd0);

      // Fresh MUL 6 x 7 after the abort.
      @(posedge clk_i); #1;
      v = '{"mul_6x7", 2'b10, 10'b0000001_000, 1'b0, 3, 32'd6, 4, 32'd7, 32'd0,
            1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 32'd0};
      apply(v);
      sb1.push_back('{"mul_6x7", 32'd42, 32'd7, 33});
      sb4.push_back('{"mul_6x7", 32'd42, 32'd7, 9});
      watch_mul(80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
